// File: rtl/mul_div_unit.sv
// Multi-cycle RV M-extension execute unit: iterative shift-add multiply and restoring divide.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle full multiplier instead of the iterative path.
module mul_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [4:0]      rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_wen
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0]   ZERO   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]   ONES   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]   ONE    = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [2*XLEN-1:0] ONE2   = {{(2*XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      op_r;
   logic            neg_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] hi_r;
   logic [XLEN-1:0] lo_r;
   logic [CW-1:0]   cnt_r;

   logic            s1_signed, s2_signed, s1_neg, s2_neg, neg_in;
   logic [XLEN-1:0] mag1, mag2;
   logic            spec_hit;
   logic [XLEN-1:0] spec_result;
   logic [XLEN-1:0] step_hi, step_lo, fin_result;
   logic [XLEN:0]   mul_sum, rem_sh;
   logic [XLEN+1:0] diff;
   logic [2*XLEN-1:0] prod;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + ONE) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + ONE2) : v;
   endfunction

`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN+1:0] fast_p;
`endif

   // Request decode: operand signedness, magnitudes, result sign and single-step special cases
   always_comb begin
      s1_signed   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      s2_signed   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      s1_neg      = s1_signed & src1[XLEN-1];
      s2_neg      = s2_signed & src2[XLEN-1];
      mag1        = cond_neg(src1, s1_neg);
      mag2        = cond_neg(src2, s2_neg);
      neg_in      = (op == 3'b110) ? s1_neg : (s1_neg ^ s2_neg);
      spec_hit    = 1'b0;
      spec_result = ZERO;
      if (op[2] && (src2 == ZERO)) begin
         spec_hit    = 1'b1;
         spec_result = op[1] ? src1 : ONES;
      end else if (op[2] && !op[0] && (src1 == MOST_NEG) && (src2 == ONES)) begin
         spec_hit    = 1'b1;
         spec_result = op[1] ? ZERO : src1;
      end else begin
`ifdef MDU_FAST_MUL_EN
         fast_a = {s1_neg, src1};
         fast_b = {s2_neg, src2};
         fast_p = fast_a * fast_b;
         if (!op[2]) begin
            spec_hit    = 1'b1;
            spec_result = (op == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
         end else begin
            spec_hit    = 1'b0;
         end
`else
         spec_hit    = 1'b0;
`endif
      end
   end

   // One iteration of shift-add or restoring division, plus the final signed result
   always_comb begin
      mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {1'b0, ZERO});
      rem_sh  = {hi_r, lo_r[XLEN-1]};
      diff    = {1'b0, rem_sh} - {2'b00, b_r};
      if (!op_r[2]) begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_r[XLEN-1:1]};
      end else if (!diff[XLEN+1]) begin
         step_hi = diff[XLEN-1:0];
         step_lo = {lo_r[XLEN-2:0], 1'b1};
      end else begin
         step_hi = rem_sh[XLEN-1:0];
         step_lo = {lo_r[XLEN-2:0], 1'b0};
      end
      prod = cond_neg2({step_hi, step_lo}, neg_r);
      if (!op_r[2]) begin
         fin_result = (op_r == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else begin
         fin_result = cond_neg(op_r[1] ? step_hi : step_lo, neg_r);
      end
   end

   // Next-state logic; flush overrides every other transition
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = in_valid ? (spec_hit ? DONE : CALC) : IDLE;
            CALC:    state_nxt = (cnt_r == {CW{1'b0}}) ? DONE : CALC;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture, iteration datapath and result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r       <= 3'b000;
         neg_r      <= 1'b0;
         b_r        <= ZERO;
         hi_r       <= ZERO;
         lo_r       <= ZERO;
         cnt_r      <= {CW{1'b0}};
         out_result <= ZERO;
         out_rd     <= 5'd0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r   <= op;
                  neg_r  <= neg_in;
                  out_rd <= rd;
                  b_r    <= op[2] ? mag2 : mag1;
                  lo_r   <= op[2] ? mag1 : mag2;
                  hi_r   <= ZERO;
                  cnt_r  <= CW'(XLEN - 1);
                  if (spec_hit) begin
                     out_result <= spec_result;
                  end
               end
            end
            CALC: begin
               hi_r  <= step_hi;
               lo_r  <= step_lo;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == {CW{1'b0}}) begin
                  out_result <= fin_result;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_wen   = out_valid && (out_rd != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors pushed on accept, monitor checks on output handshake.
module tb_mul_div_unit;
   localparam int XLEN = 64;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 65;
`endif
   localparam int DIV_LAT  = 65;
   localparam int SPEC_LAT = 1;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, flush, out_valid, out_ready, out_wen;
   logic [2:0]      op;
   logic [XLEN-1:0] src1, src2, out_result;
   logic [4:0]      rd, out_rd;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rd;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;

   mul_div_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2), .rd(rd), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor
   logic        prev_valid = 1'b0;
   logic [63:0] prev_res;
   logic [4:0]  prev_rd;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (!prev_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
            else chk("latency", 64'(cyc + 1 - sb[0].acc), 64'(sb[0].lat));
         end else begin
            chk("hold_result", out_result, prev_res);
            chk("hold_rd", 64'(out_rd), 64'(prev_rd));
         end
         if (out_ready && !flush && sb.size() > 0) begin
            e = sb.pop_front();
            chk("result", out_result, e.res);
            chk("rd", 64'(out_rd), 64'(e.rd));
            chk("wen", 64'(out_wen), 64'(e.rd != 5'd0));
         end
      end
      prev_valid = (out_valid === 1'b1);
      prev_res   = out_result;
      prev_rd    = out_rd;
   end

   task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] r, input logic [63:0] exp, input int lat, input bit push);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; src1 = a; src2 = b; rd = r;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) sb.push_back('{exp, r, lat, cyc});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int n;
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      op = 3'b000; src1 = '0; src2 = '0; rd = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_wen", 64'(out_wen), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_rd", 64'(out_rd), 64'd0);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      issue(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 1'b1); drain();
      issue(3'b011, ONES, ONES, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT, 1'b1); drain();
      issue(3'b001, ONES, ONES, 5'd2, 64'd0, MUL_LAT, 1'b1); drain();
      issue(3'b010, ONES, 64'd2, 5'd3, ONES, MUL_LAT, 1'b1); drain();
      issue(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT, 1'b1); drain();
      issue(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, ONES, DIV_LAT, 1'b1); drain();
      issue(3'b101, 64'd100, 64'd7, 5'd7, 64'd14, DIV_LAT, 1'b1); drain();
      issue(3'b111, 64'd100, 64'd7, 5'd8, 64'd2, DIV_LAT, 1'b1); drain();
      issue(3'b101, 64'd5, 64'd0, 5'd10, ONES, SPEC_LAT, 1'b1); drain();
      issue(3'b111, 64'd5, 64'd0, 5'd11, 64'd5, SPEC_LAT, 1'b1); drain();
      issue(3'b100, 64'h8000_0000_0000_0000, ONES, 5'd12, 64'h8000_0000_0000_0000, SPEC_LAT, 1'b1); drain();
      issue(3'b110, 64'h8000_0000_0000_0000, ONES, 5'd13, 64'd0, SPEC_LAT, 1'b1); drain();
      issue(3'b000, 64'd3, 64'd4, 5'd0, 64'd12, MUL_LAT, 1'b1); drain();

      // Backpressure: hold out_ready low for 10 cycles in DONE
      out_ready = 1'b0;
      issue(3'b101, 64'd1000, 64'd10, 5'd9, 64'd100, DIV_LAT, 1'b1);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", 64'(out_valid), 64'd1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #2 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      drain();

      // Flush 20 cycles into CALC
      issue(3'b101, 64'd100, 64'd7, 5'd14, 64'd0, DIV_LAT, 1'b0);
      repeat (20) @(posedge clk);
      #2 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (70) @(negedge clk);

      // Reset mid-CALC
      issue(3'b111, 64'd100, 64'd7, 5'd15, 64'd0, DIV_LAT, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_wen", 64'(out_wen), 64'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (70) @(negedge clk);

      // Unit still works after reset
      issue(3'b110, 64'd17, 64'd5, 5'd16, 64'd2, DIV_LAT, 1'b1); drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle RV M-extension execute unit sitting between the register file read ports and the register file write port. Takes the two source operands read for an M-type instruction, computes the product or quotient/remainder over several cycles, and presents the result with its destination register index and a write enable for register writeback. Uses a valid/ready handshake on both sides so the core can stall while the unit is busy.

## Interface
- XLEN, 64, operand/result width (power of two, ≥ 8)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request (high only in IDLE)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  XLEN  rs1 value (dividend / multiplicand)
- src2  in  XLEN  rs2 value (divisor / multiplier)
- rd  in  5  destination register index
- flush  in  1  abort any in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_rd  out  5  captured rd
- out_wen  out  1  out_valid && out_rd != 0

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid: latch op, rd, operand magnitudes and result sign; go to CALC, or directly to DONE for special cases below.
- CALC: one iteration per cycle, counter from XLEN-1 down to 0; at 0 go to DONE.
- Multiply: shift-add on |src1|, |src2| (signedness per op: MULH both signed, MULHSU src1 signed/src2 unsigned, MULHU/MUL unsigned treatment valid for MUL low half); 2·XLEN-bit product, two's-complement negate if sign set. MUL returns low XLEN bits, MULH* high XLEN bits.
- Divide: restoring division on magnitudes; quotient sign = sign(src1) XOR sign(src2) for DIV; remainder sign = sign(src1) for REM.
- Divide by zero (src2==0): DIV/DIVU → all ones; REM/REMU → src1. Goes IDLE→DONE, no CALC.
- Signed overflow (DIV/REM, src1 = most-negative, src2 = all ones): DIV → src1, REM → 0. Goes IDLE→DONE.
- DONE: out_valid=1, outputs held stable; on out_ready go to IDLE. No new request accepted in DONE.
- flush: from any state, next edge → IDLE, out_valid=0; flush has priority over in_valid and out_ready in the same cycle.

## Timing
- Reset (rst low, asynchronous): state IDLE; in_ready=1 after reset release, out_valid=0, out_wen=0, out_result=0, out_rd=0.
- Accept at edge N (in_valid && in_ready). Normal op: CALC cycles N+1..N+XLEN, out_valid first high in cycle N+XLEN+1.
- Special-case divide: out_valid high in cycle N+1.
- out_valid stays high until the edge where out_ready=1 (or flush); in_ready rises the cycle after.
- Minimum request-to-request spacing: normal op XLEN+2 cycles; special case 2 cycles.
- rst asserted mid-CALC/DONE: operation discarded, no write.

## Configuration
- MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU computed with a single-cycle full multiplier, IDLE→DONE, out_valid in cycle N+1; divides unchanged.
- Not defined: all multiplies use the iterative XLEN-cycle path; no multiplier operator synthesized.

## Test plan
- MUL src1=7, src2=0xFFFF_FFFF_FFFF_FFFD (−3), rd=5 → out_result 0xFFFF_FFFF_FFFF_FFEB, out_rd=5, out_wen=1, out_valid exactly 65 cycles after accept (1 with MDU_FAST_MUL_EN).
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE; MULH same operands → 0; MULHSU all-ones × 2 → all ones.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7 % 2 → all ones; DIVU 100/7 → 14, REMU → 2.
- DIVU 5/0 → all ones, REMU 5/0 → 5, DIV 0x8000_0000_0000_0000 / all-ones → 0x8000_0000_0000_0000, REM → 0; each out_valid 1 cycle after accept.
- Hold out_ready=0 for 10 cycles in DONE → out_result/out_rd stable, in_ready=0; release → IDLE next edge. rd=0 → out_valid=1, out_wen=0.
- flush 20 cycles into CALC → IDLE next edge, in_ready=1, no out_valid; rst low mid-CALC → out_valid=0 immediately, in_ready=1 after release.
